// File: rtl/cla_group_adder.sv
// Multi-cycle carry-lookahead adder: one GROUP-bit slice per cycle, LSB group first,
// accumulating block generate/propagate across groups alongside the sum.
module cla_group_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarry,
  output logic             oReady,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry,
  output logic             oGenerate,
  output logic             oPropagate
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_cin;
  logic             r_gen;
  logic             r_prop;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_gen_o;
  logic             r_prop_o;

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_s;
  logic [GROUP:0]   w_c;
  logic             w_grp_g;
  logic             w_grp_p;
  logic             w_gen_nx;
  logic             w_prop_nx;
  logic             w_last;
  logic [WIDTH-1:0] w_acc;

  // Operands shift right each RUN cycle, so the group being processed is always
  // in the low GROUP bits; the sum fills in from the top and lands aligned.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later loop iterations see
    // the ripple values just computed; registers below use '<=' exclusively.
    w_p     = '0;
    w_g     = '0;
    w_s     = '0;
    w_c     = '0;
    w_c[0]  = r_cin;
    w_grp_g = 1'b0;
    w_grp_p = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      w_p[i]   = r_a[i] | r_b[i];
      w_g[i]   = r_a[i] & r_b[i];
      w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      w_grp_g  = w_g[i] | (w_p[i] & w_grp_g);
      w_grp_p  = w_grp_p & w_p[i];
    end
  end

  assign w_gen_nx  = w_grp_g | (w_grp_p & r_gen);
  assign w_prop_nx = r_prop & w_grp_p;
  assign w_last    = (r_cnt == LAST_GRP);
  assign w_acc     = (r_acc >> GROUP) | (WIDTH'(w_s) << (WIDTH - GROUP));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iStart) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_cin    <= 1'b0;
      r_gen    <= 1'b0;
      r_prop   <= 1'b1;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_gen_o  <= 1'b0;
      r_prop_o <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_a    <= iA;
            r_b    <= iB;
            r_cin  <= iCarry;
            r_cnt  <= '0;
            r_gen  <= 1'b0;
            r_prop <= 1'b1;
          end
        end
        RUN: begin
          r_a    <= r_a >> GROUP;
          r_b    <= r_b >> GROUP;
          r_acc  <= w_acc;
          r_cin  <= w_c[GROUP];
          r_gen  <= w_gen_nx;
          r_prop <= w_prop_nx;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum    <= w_acc;
            r_cout   <= w_c[GROUP];
            r_gen_o  <= w_gen_nx;
            r_prop_o <= w_prop_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign oReady     = (r_state == IDLE);
  assign oDone      = (r_state == DONE);
  assign oSum       = r_sum;
  assign oCarry     = r_cout;
  assign oGenerate  = r_gen_o;
  assign oPropagate = r_prop_o;

endmodule

// File: tb/tb_cla_group_adder.sv
// Scoreboard bench for cla_group_adder: a cycle model of ready/done timing plus a
// queue of arithmetic results checked against every output on every cycle.
module tb_cla_group_adder;

  localparam int WIDTH = 32;
  localparam int GROUP = 4;
  localparam int NGRP  = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             gen;
    logic             prop;
  } res_t;

  logic             iClk;
  logic             iRst;
  logic             iStart;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCarry;
  logic             oReady;
  logic             oDone;
  logic [WIDTH-1:0] oSum;
  logic             oCarry;
  logic             oGenerate;
  logic             oPropagate;

  res_t q[$];
  res_t m_last;
  int   m_busy;
  bit   m_live;
  int   checks;
  int   failures;

  cla_group_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iStart     (iStart),
    .iA         (iA),
    .iB         (iB),
    .iCarry     (iCarry),
    .oReady     (oReady),
    .oDone      (oDone),
    .oSum       (oSum),
    .oCarry     (oCarry),
    .oGenerate  (oGenerate),
    .oPropagate (oPropagate)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic: block generate equals the carry-out with zero carry-in,
  // block propagate (OR form) is every bit position having at least one 1.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    res_t           r;
    logic [WIDTH:0] s;
    logic [WIDTH:0] s0;
    s0      = {1'b0, a} + {1'b0, b};
    s       = s0 + {{WIDTH{1'b0}}, c};
    r.sum   = s[WIDTH-1:0];
    r.carry = s[WIDTH];
    r.gen   = s0[WIDTH];
    r.prop  = &(a | b);
    return r;
  endfunction

  // Cycle model: accept in idle, busy for NGRP RUN cycles plus one DONE cycle.
  always @(posedge iClk) begin
    if (iRst) begin
      m_busy <= 0;
      m_last <= '0;
      q.delete();
      m_live <= 1'b1;
    end else if (m_busy == 0) begin
      if (iStart) begin
        q.push_back(model(iA, iB, iCarry));
        m_busy <= NGRP + 1;
      end
    end else begin
      if (m_busy == 2) m_last <= q.pop_front();
      m_busy <= m_busy - 1;
    end
  end

  always @(negedge iClk) begin
    if (m_live) begin
      check("ready", oReady, m_busy == 0);
      check("done", oDone, m_busy == 1);
      check("sum", oSum, m_last.sum);
      check("carry", oCarry, m_last.carry);
      check("generate", oGenerate, m_last.gen);
      check("propagate", oPropagate, m_last.prop);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 4 * NGRP && m_busy != 0; i++) @(negedge iClk);
    check("idle_ready", oReady, 1'b1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    iStart = 1'b1;
    iA     = a;
    iB     = b;
    iCarry = c;
    @(negedge iClk);
    iStart = 1'b0;
    iA     = $urandom;
    iB     = $urandom;
    iCarry = 1'($urandom);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_busy   = 0;
    m_live   = 1'b0;
    m_last   = '0;
    iRst     = 1'b1;
    iStart   = 1'b0;
    iA       = '0;
    iB       = '0;
    iCarry   = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle();
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1);
    wait_idle();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_idle();

    // Start requests while busy must be ignored and late operands must not leak in.
    run_op('0, '0, 1'b1);
    iA = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      iStart = (i % 2 == 0);
      @(negedge iClk);
    end
    iStart = 1'b0;
    wait_idle();

    // Reset mid-operation aborts with no done pulse, then a fresh start completes.
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle();

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge iClk);
      run_op($urandom, $urandom, 1'($urandom));
      wait_idle();
    end

    // Start held high: a new operation every NGRP+2 cycles with whatever operands
    // are on the bus at each accepting edge.
    iStart = 1'b1;
    for (int n = 0; n < 5 * (NGRP + 2); n++) begin
      iA     = $urandom;
      iB     = $urandom;
      iCarry = 1'($urandom);
      @(negedge iClk);
    end
    iStart = 1'b0;
    wait_idle();
    repeat (2) @(negedge iClk);

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_group_adder.md
CLA_GROUP_ADDER -- requirements
Module: cla_group_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; WIDTH SHALL be a multiple of GROUP.
REQ-002 Parameter: GROUP, 4, bits processed per cycle; NGRP = WIDTH/GROUP.
REQ-003 iClk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-004 iRst  in  1  reset; synchronous, active-high.
REQ-005 iStart  in  1  request to begin an addition; sampled only in IDLE.
REQ-006 iA  in  WIDTH  operand A; captured on an accepted start.
REQ-007 iB  in  WIDTH  operand B; captured on an accepted start.
REQ-008 iCarry  in  1  carry-in; captured on an accepted start.
REQ-009 oReady  out  1  high only in IDLE, meaning a start will be accepted.
REQ-010 oDone  out  1  one-cycle pulse; results are valid.
REQ-011 oSum  out  WIDTH  sum result.
REQ-012 oCarry  out  1  carry-out of bit WIDTH-1.
REQ-013 oGenerate  out  1  block generate over all WIDTH bits.
REQ-014 oPropagate  out  1  block propagate over all WIDTH bits.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE only; any unreachable encoding SHALL go to IDLE on the next edge.
REQ-016 In IDLE with iStart=1, the edge SHALL latch iA, iB and iCarry, clear the group counter and enter RUN.
- The running block-generate and running block-propagate SHALL be initialised to 0 and 1.
- oSum, oCarry, oGenerate and oPropagate SHALL hold their previous values until DONE.
REQ-017 In RUN, each edge SHALL process group k = counter (bits k*GROUP .. k*GROUP+GROUP-1), LSB group first, then increment the counter.
REQ-018 Per bit i: p_i = a_i | b_i, g_i = a_i & b_i, s_i = a_i ^ b_i ^ c_i, c_{i+1} = g_i | (p_i & c_i).
- c for bit 0 of group 0 SHALL be the latched iCarry.
- c for bit 0 of group k>0 SHALL be the registered carry-out of group k-1.
REQ-019 Group generate Gk and group propagate Pk SHALL be computed by lookahead over the group's g/p.
- Running generate SHALL update as Gk | (Pk & running generate).
- Running propagate SHALL update as running propagate & Pk.
REQ-020 On the edge that processes group NGRP-1, the FSM SHALL enter DONE.
- On that edge, oSum, oCarry, oGenerate and oPropagate SHALL be updated from the completed computation.
REQ-021 In DONE, oDone SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE regardless of iStart.
REQ-022 Latency: with start sampled at edge N, oDone SHALL be high between edges N+NGRP and N+NGRP+1 (8 cycles at the defaults).
- oReady SHALL be high again after edge N+NGRP+1.
REQ-023 iStart in RUN or DONE SHALL be ignored.
- Operand changes after capture SHALL NOT affect the result.
REQ-024 Outputs SHALL hold their last result until the next DONE.
REQ-025 All arithmetic SHALL be modulo 2^WIDTH; the overflow bit SHALL appear only on oCarry.

Reset
REQ-026 With iRst=1 at an edge: state SHALL become IDLE, and the counter and all internal registers SHALL be 0, except running propagate = 1.
- oSum=0, oCarry=0, oGenerate=0, oPropagate=0, oDone=0 and oReady=1 from the following cycle.
REQ-027 iRst SHALL take priority over iStart and over any RUN or DONE activity.
- A reset mid-operation SHALL abort the addition with no oDone pulse.

Verification (WIDTH=32, GROUP=4)
REQ-028 A=0xFFFFFFFF, B=0x00000001, Cin=0 -> after 8 cycles oDone=1, oSum=0x00000000, oCarry=1, oGenerate=1, oPropagate=1.
REQ-029 A=0x12345678, B=0x11111111, Cin=1 -> oSum=0x2345678A, oCarry=0, oGenerate=0, oPropagate=0.
REQ-030 A=0x80000000, B=0x80000000, Cin=0 -> oSum=0x00000000, oCarry=1, oGenerate=1, oPropagate=0.
REQ-031 Start A=0, B=0, Cin=1, then pulse iStart with A=0xFFFFFFFF in cycles 2..9 -> single oDone, oSum=0x00000001, oCarry=0; oReady=0 for the whole operation.
REQ-032 Start any operands, assert iRst at cycle 4 -> no oDone, all outputs 0, oReady=1.
- A new start immediately after reset SHALL complete normally, 8 cycles later.
REQ-033 Back-to-back: iStart held high continuously -> oDone pulses every 10 cycles, each result correct for the operands present at its accepting edge.
